nivel_reservatorio_ctrl: RTL

- Upstream stage of the irrigation system's 7-segment display decoder.
- Synchronises and debounces three reservoir level probes, then classifies the water level as critical, low, medium, high or error.
- Drives the one-hot level flags (Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, Err) consumed by the display decoder.
- Generates the periodic display-select signal Sd that alternates the display between level view and irrigation-type view.

---
 rtl/nivel_reservatorio_ctrl_pkg.sv | 36 +++
 rtl/debounce_sync.sv | 43 ++++
 rtl/nivel_reservatorio_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/nivel_reservatorio_ctrl_pkg.sv
// Shared types and constants for the reservoir level controller.
// Holds the state encoding, the probe patterns and the pattern classifier.
package nivel_reservatorio_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    CRITICO = 3'd1,
    BAIXO   = 3'd2,
    MEDIO   = 3'd3,
    ALTO    = 3'd4,
    ERRO    = 3'd5
  } nivel_state_t;

  localparam logic [2:0] P_CRIT  = 3'b000;
  localparam logic [2:0] P_BAIXO = 3'b001;
  localparam logic [2:0] P_MEDIO = 3'b011;
  localparam logic [2:0] P_ALTO  = 3'b111;

  // Probes fill from the bottom, so any pattern with a gap is physically impossible.
  function automatic nivel_state_t classify(input logic [2:0] p);
    nivel_state_t s;
    case (p)
      P_CRIT:  s = CRITICO;
      P_BAIXO: s = BAIXO;
      P_MEDIO: s = MEDIO;
      P_ALTO:  s = ALTO;
      default: s = ERRO;
    endcase
    return s;
  endfunction

  function automatic logic is_level(input nivel_state_t s);
    return (s == CRITICO) || (s == BAIXO) || (s == MEDIO) || (s == ALTO);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus debounce: a pattern is accepted once the
// synchronised value has been stable for DEB_CYCLES consecutive comparisons.
module debounce_sync #(
  parameter int unsigned W          = 3,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         accept
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cand  <= sync2;
      if (sync2 != cand)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Counter saturates, so a stable pattern keeps re-asserting accept every cycle.
  assign accept = (sync2 == cand) && (cnt == CNT_MAX);
  assign dout   = sync2;

endmodule

// File: rtl/nivel_reservatorio_ctrl.sv
// Reservoir level classifier and display-select generator feeding the 7-seg decoder.
// Build option ERR_LATCH_EN: ERRO becomes sticky and is cleared by the Err_Clr input.
module nivel_reservatorio_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned SD_PERIOD  = 50000000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] Sensor,
`ifdef ERR_LATCH_EN
  input  logic       Err_Clr,
`endif
  output logic       Nv_Critico,
  output logic       Nv_Baixo,
  output logic       Nv_Medio,
  output logic       Nv_Alto,
  output logic       Err,
  output logic       Sd
);

  import nivel_reservatorio_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(SD_PERIOD - 1);

  logic [2:0]       pattern;
  logic             accept;
  nivel_state_t     state;
  nivel_state_t     next_state;
  logic [CNT_W-1:0] sd_cnt;

  debounce_sync #(
    .W          (3),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .din    (Sensor),
    .dout   (pattern),
    .accept (accept)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n)
      state <= INIT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
`ifdef ERR_LATCH_EN
    if (state == ERRO) begin
      if (Err_Clr)
        next_state = INIT;
    end else if (accept) begin
      next_state = classify(pattern);
    end
`else
    if (accept)
      next_state = classify(pattern);
`endif
  end

  always_comb begin
    Nv_Critico = (state == CRITICO);
    Nv_Baixo   = (state == BAIXO);
    Nv_Medio   = (state == MEDIO);
    Nv_Alto    = (state == ALTO);
    Err        = (state == ERRO);
  end

  // Gating on both current and next state makes entry into ERRO win over a
  // simultaneous wrap, and makes the edge leaving INIT/ERRO start at count 0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sd_cnt <= '0;
      Sd     <= 1'b0;
    end else if (!(is_level(state) && is_level(next_state))) begin
      sd_cnt <= '0;
      Sd     <= 1'b0;
    end else if (sd_cnt == SD_LAST) begin
      sd_cnt <= '0;
      Sd     <= ~Sd;
    end else begin
      sd_cnt <= sd_cnt + 1'b1;
    end
  end

endmodule
